osc_scan_ctrl: RTL



---
 rtl/osc_scan_pkg.sv | 23 ++
 rtl/osc_sync2.sv | 21 ++
 rtl/osc_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/osc_scan_pkg.sv
// Shared types and parameter defaults for the oscillation scan controller.
// Imported by the top module so state encoding and defaults live in one place.
package osc_scan_pkg;

  localparam int VEC_W_DEF      = 8;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int WINDOW_CYC_DEF = 16;
  localparam int THRESH_DEF     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_DONE
  } scan_state_t;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/osc_sync2.sv
// Two-flop synchronizer bringing an asynchronous netlist node into the clk domain.
module osc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/osc_scan_ctrl.sv
// Steps a stimulus vector across [vec_lo, vec_hi], watches the feedback node for
// oscillation after each vector settles, and records which vectors made it ring.
module osc_scan_ctrl
  import osc_scan_pkg::*;
#(
  parameter int VEC_W      = VEC_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int WINDOW_CYC = WINDOW_CYC_DEF,
  parameter int THRESH     = THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [VEC_W-1:0] vec_lo,
  input  logic [VEC_W-1:0] vec_hi,
  input  logic             probe_in,
  input  logic             osc_flag_in,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             err_range,
  output logic             hit,
  output logic [VEC_W-1:0] first_hit_vec,
  output logic [VEC_W:0]   hit_count
);

  localparam int PH_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int PH_W   = cnt_width(PH_MAX);
  localparam int TOG_W  = cnt_width(THRESH);

  localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
  localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW_CYC - 1);
  localparam logic [TOG_W-1:0] THRESH_V    = TOG_W'(THRESH);

  scan_state_t      state;
  logic [VEC_W-1:0] hi_q;
  logic [PH_W-1:0]  ph_cnt;
  logic [TOG_W-1:0] tog_cnt;
  logic             seen;
  logic             probe_sync;
  logic             probe_prev;
  logic             flag_sync;
  logic             probe_edge;
  logic             osc_now;

  osc_sync2 u_sync_probe (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (probe_in),
    .q     (probe_sync)
  );

  osc_sync2 u_sync_flag (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (osc_flag_in),
    .q     (flag_sync)
  );

  assign probe_edge = probe_sync ^ probe_prev;
  assign osc_now    = (tog_cnt >= THRESH_V) || seen;

  // Abort overrides everything outside IDLE; partial results are deliberately kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      hi_q          <= '0;
      ph_cnt        <= '0;
      tog_cnt       <= '0;
      seen          <= 1'b0;
      probe_prev    <= 1'b0;
      vec_out       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_range     <= 1'b0;
      hit           <= 1'b0;
      first_hit_vec <= '0;
      hit_count     <= '0;
    end else begin
      err_range  <= 1'b0;
      done       <= 1'b0;
      probe_prev <= probe_sync;
      if (abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              if (vec_lo > vec_hi) begin
                err_range <= 1'b1;
              end else begin
                hi_q          <= vec_hi;
                vec_out       <= vec_lo;
                hit           <= 1'b0;
                first_hit_vec <= '0;
                hit_count     <= '0;
                ph_cnt        <= '0;
                busy          <= 1'b1;
                state         <= ST_SETTLE;
              end
            end
          end
          ST_SETTLE: begin
            if (ph_cnt == SETTLE_LAST) begin
              ph_cnt  <= '0;
              tog_cnt <= '0;
              seen    <= 1'b0;
              state   <= ST_SAMPLE;
            end else begin
              ph_cnt <= ph_cnt + PH_W'(1);
            end
          end
          ST_SAMPLE: begin
            if (probe_edge && (tog_cnt < THRESH_V)) begin
              tog_cnt <= tog_cnt + TOG_W'(1);
            end
            if (flag_sync) begin
              seen <= 1'b1;
            end
            if (ph_cnt == WINDOW_LAST) begin
              ph_cnt <= '0;
              state  <= ST_EVAL;
            end else begin
              ph_cnt <= ph_cnt + PH_W'(1);
            end
          end
          ST_EVAL: begin
            if (osc_now) begin
              if (!hit) begin
                hit           <= 1'b1;
                first_hit_vec <= vec_out;
              end
              hit_count <= hit_count + {{VEC_W{1'b0}}, 1'b1};
            end
            // Stop on the last vector before incrementing so all-ones never wraps.
            if (vec_out == hi_q) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              vec_out <= vec_out + {{(VEC_W-1){1'b0}}, 1'b1};
              ph_cnt  <= '0;
              state   <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
